// File: rtl/alu_seq_pkg.sv
// Shared opcode and state definitions for the sequenced ALU engine.
package alu_seq_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
   localparam logic [OP_W-1:0] OP_AND  = 3'b010;
   localparam logic [OP_W-1:0] OP_OR   = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
   localparam logic [OP_W-1:0] OP_SHL  = 3'b101;
   localparam logic [OP_W-1:0] OP_MUL  = 3'b110;
   localparam logic [OP_W-1:0] OP_PASS = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      MUL  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/alu_seq_engine_if.sv
// Operand/opcode request and result/status bundle between a source and the engine.
interface alu_seq_engine_if #(parameter int WIDTH = 6) ();

   logic                          start;
   logic [WIDTH-1:0]              a;
   logic [WIDTH-1:0]              b;
   logic [alu_seq_pkg::OP_W-1:0]  op;
   logic                          ready;
   logic                          done;
   logic [WIDTH-1:0]              result;
   logic                          flag;
   logic                          zero;

   modport master (output start, a, b, op, input ready, done, result, flag, zero);
   modport slave  (input start, a, b, op, output ready, done, result, flag, zero);

endinterface

// File: rtl/alu_seq_core.sv
// Single-cycle combinational datapath for every opcode except MUL.
module alu_seq_core
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic [WIDTH-1:0] result,
   output logic             flag
);

   localparam logic [WIDTH:0] SHIFT_LIM = (WIDTH+1)'(WIDTH);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;
   logic [WIDTH:0] shl_ext;

   assign sum     = {1'b0, a} + {1'b0, b};
   assign diff    = {1'b0, a} - {1'b0, b};
   // bit WIDTH of the extended shift is the last bit pushed out of the result
   assign shl_ext = {1'b0, a} << b;

   always_comb begin
      result = '0;
      flag   = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum[WIDTH-1:0];
            flag   = sum[WIDTH];
         end
         OP_SUB: begin
            result = diff[WIDTH-1:0];
            flag   = diff[WIDTH];
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SHL: begin
            if ({1'b0, b} < SHIFT_LIM) begin
               result = shl_ext[WIDTH-1:0];
               flag   = shl_ext[WIDTH];
            end
         end
         OP_PASS: result = b;
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_seq_engine.sv
// Handshaked ALU engine: FSM, operand/output registers and the iterative shift-add multiplier.
//
//   state | meaning
//   IDLE  | ready=1, waiting for start
//   EXEC  | operands registered; single-cycle result captured or MUL set up
//   MUL   | one multiplier bit per cycle, WIDTH cycles
//   DONE  | done pulse; result/flag/zero valid
module alu_seq_engine
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             reset,
   alu_seq_engine_if.slave  bus
);

   localparam int             CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);

   state_t state, state_nxt;

   logic [WIDTH-1:0]   a_q, b_q;
   logic [OP_W-1:0]    op_q;
   logic [2*WIDTH-1:0] acc_q, mcand_q, acc_nxt;
   logic [WIDTH-1:0]   mplier_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   result_q;
   logic               flag_q, zero_q;

   logic [WIDTH-1:0]   core_result;
   logic               core_flag;

   alu_seq_core #(.WIDTH(WIDTH)) u_core (
      .a      (a_q),
      .b      (b_q),
      .op     (op_q),
      .result (core_result),
      .flag   (core_flag)
   );

   assign acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = EXEC;
         EXEC:    state_nxt = (op_q == OP_MUL) ? MUL : DONE;
         MUL:     if (cnt_q == CNT_LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         flag_q   <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_q  <= bus.a;
                  b_q  <= bus.b;
                  op_q <= bus.op;
               end
            end
            EXEC: begin
               if (op_q == OP_MUL) begin
                  acc_q    <= '0;
                  mcand_q  <= {{WIDTH{1'b0}}, a_q};
                  mplier_q <= b_q;
                  cnt_q    <= '0;
               end else begin
                  result_q <= core_result;
                  flag_q   <= core_flag;
                  zero_q   <= (core_result == '0);
               end
            end
            MUL: begin
               acc_q    <= acc_nxt;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               // last partial product is folded in combinationally so DONE sees the final value
               if (cnt_q == CNT_LAST) begin
                  result_q <= acc_nxt[WIDTH-1:0];
                  flag_q   <= |acc_nxt[2*WIDTH-1:WIDTH];
                  zero_q   <= (acc_nxt[WIDTH-1:0] == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ready  = (state == IDLE);
   assign bus.done   = (state == DONE);
   assign bus.result = result_q;
   assign bus.flag   = flag_q;
   assign bus.zero   = zero_q;

endmodule

// File: tb/tb_alu_seq_engine.sv
// Self-checking bench: 6-bit and 16-bit engines against a cycle-level arithmetic model plus directed literals.
module tb_alu_seq_engine;
   import alu_seq_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_seq_engine_if #(.WIDTH(6))  bus6 ();
   alu_seq_engine_if #(.WIDTH(16)) bus16 ();

   alu_seq_engine #(.WIDTH(6))  dut6  (.clk(clk), .reset(reset), .bus(bus6.slave));
   alu_seq_engine #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));

   int checks = 0;
   int passed = 0;
   int W [2] = '{6, 16};

   task automatic check(string name, longint act, longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic drive(int i, bit st, longint a, longint b, int op);
      if (i == 0) begin
         bus6.start = st;  bus6.a = 6'(a);   bus6.b = 6'(b);   bus6.op = 3'(op);
      end else begin
         bus16.start = st; bus16.a = 16'(a); bus16.b = 16'(b); bus16.op = 3'(op);
      end
   endtask

   function automatic void get_in(int i, output bit st, output longint a, output longint b, output int op);
      if (i == 0) begin
         st = bus6.start;  a = longint'(bus6.a);  b = longint'(bus6.b);  op = int'(bus6.op);
      end else begin
         st = bus16.start; a = longint'(bus16.a); b = longint'(bus16.b); op = int'(bus16.op);
      end
   endfunction

   function automatic void get_out(int i, output bit rdy, output bit dn, output longint r,
                                   output bit f, output bit z);
      if (i == 0) begin
         rdy = bus6.ready;  dn = bus6.done;  r = longint'(bus6.result);  f = bus6.flag;  z = bus6.zero;
      end else begin
         rdy = bus16.ready; dn = bus16.done; r = longint'(bus16.result); f = bus16.flag; z = bus16.zero;
      end
   endfunction

   // Arithmetic meaning of each opcode on w-bit unsigned values.
   function automatic void calc(int w, int op, longint a, longint b, output longint r, output bit f);
      longint mask = (longint'(1) << w) - 1;
      longint s;
      r = 0;
      f = 1'b0;
      case (op)
         0: begin s = a + b; r = s & mask; f = (s > mask); end
         1: begin r = (a - b) & mask; f = (a < b); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: begin
            if (b == 0) r = a;
            else if (b < w) begin
               s = a << b;
               r = s & mask;
               f = ((s >> w) & 1) != 0;
            end
         end
         6: begin s = a * b; r = s & mask; f = ((s >> w) != 0); end
         default: r = b;
      endcase
   endfunction

   // Model state: which cycle (edge count) the pending op reports done in, and the held outputs.
   longint cyc = 0;
   bit     mvalid = 1'b0;
   bit     busy [2];
   longint done_cyc [2];
   longint pend_r [2];
   bit     pend_f [2];
   longint held_r [2];
   bit     held_f [2];
   bit     held_z [2];

   initial forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
         bit st; longint a, b; int op;
         get_in(i, st, a, b, op);
         if (reset) begin
            busy[i] = 1'b0; held_r[i] = 0; held_f[i] = 1'b0; held_z[i] = 1'b0;
            done_cyc[i] = -10;
            mvalid = 1'b1;
         end else if (!busy[i] && st) begin
            busy[i] = 1'b1;
            calc(W[i], op, a, b, pend_r[i], pend_f[i]);
            done_cyc[i] = cyc + 1 + ((op == 6) ? W[i] : 0);
         end else if (busy[i]) begin
            if (cyc == done_cyc[i]) begin
               held_r[i] = pend_r[i]; held_f[i] = pend_f[i]; held_z[i] = (pend_r[i] == 0);
            end else if (cyc == done_cyc[i] + 1) begin
               busy[i] = 1'b0;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (mvalid) begin
         for (int i = 0; i < 2; i++) begin
            bit rdy, dn, f, z; longint r;
            get_out(i, rdy, dn, r, f, z);
            check($sformatf("w%0d_ready@%0d", W[i], cyc), rdy, !busy[i]);
            check($sformatf("w%0d_done@%0d", W[i], cyc), dn, busy[i] && (cyc == done_cyc[i]));
            check($sformatf("w%0d_result@%0d", W[i], cyc), r, held_r[i]);
            check($sformatf("w%0d_flag@%0d", W[i], cyc), f, held_f[i]);
            check($sformatf("w%0d_zero@%0d", W[i], cyc), z, held_z[i]);
         end
      end
   end

   task automatic run_op(int i, int op, longint a, longint b, longint er, bit ef, bit hold);
      int n = 0;
      bit rdy, dn, f, z;
      longint r;
      @(negedge clk);
      drive(i, 1'b1, a, b, op);
      do begin
         @(negedge clk);
         n++;
         if (hold) drive(i, 1'b1, $urandom, $urandom, op);
         else      drive(i, 1'b0, $urandom, $urandom, op);
         get_out(i, rdy, dn, r, f, z);
      end while (!dn && n < 40);
      check($sformatf("w%0d_op%0d_latency", W[i], op), n, 2 + ((op == 6) ? W[i] : 0));
      check($sformatf("w%0d_op%0d_result", W[i], op), r, er);
      check($sformatf("w%0d_op%0d_flag", W[i], op), f, ef);
      check($sformatf("w%0d_op%0d_zero", W[i], op), z, er == 0);
      if (hold) begin
         @(negedge clk);
         drive(i, 1'b0, 0, 0, 0);
         get_out(i, rdy, dn, r, f, z);
         check("hold_ready_after", rdy, 1);
         check("hold_no_second_done", dn, 0);
      end
   endtask

   initial begin
      bit rdy, dn, f, z;
      longint r;
      reset = 1'b1;
      drive(0, 1'b0, 0, 0, 0);
      drive(1, 1'b0, 0, 0, 0);
      repeat (2) @(negedge clk);
      get_out(0, rdy, dn, r, f, z);
      check("reset_ready", rdy, 1);
      check("reset_result", r, 0);
      reset = 1'b0;

      run_op(0, 0, 40, 30, 6, 1, 0);
      run_op(0, 1, 5, 5, 0, 0, 0);
      run_op(0, 1, 3, 4, 63, 1, 0);
      run_op(0, 2, 44, 26, 8, 0, 0);
      run_op(0, 3, 44, 26, 62, 0, 0);
      run_op(0, 4, 44, 26, 54, 0, 0);
      run_op(0, 5, 33, 1, 2, 1, 0);
      run_op(0, 5, 33, 6, 0, 0, 0);
      run_op(0, 5, 33, 0, 33, 0, 0);
      run_op(0, 5, 3, 5, 32, 1, 0);
      run_op(0, 6, 7, 9, 63, 0, 0);
      run_op(0, 6, 20, 5, 36, 1, 0);
      run_op(0, 7, 1, 45, 45, 0, 0);
      run_op(0, 6, 7, 9, 63, 0, 1);

      // abort a MUL in its third iteration
      @(negedge clk);
      drive(0, 1'b1, 20, 5, 6);
      repeat (4) begin
         @(negedge clk);
         drive(0, 1'b0, 0, 0, 0);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      get_out(0, rdy, dn, r, f, z);
      check("abort_ready", rdy, 1);
      check("abort_done", dn, 0);
      check("abort_result", r, 0);
      check("abort_flag", f, 0);
      check("abort_zero", z, 0);
      run_op(0, 0, 1, 1, 2, 0, 0);

      run_op(1, 0, 40000, 30000, 4464, 1, 0);
      run_op(1, 6, 7, 9, 63, 0, 0);
      run_op(1, 6, 300, 300, 24464, 1, 0);
      run_op(1, 5, 32769, 1, 2, 1, 0);
      run_op(1, 5, 32769, 16, 0, 0, 0);
      run_op(1, 1, 3, 4, 65535, 1, 0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
